// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - decoder-to-register-file dispatch controller with ROB tag allocation and unit credit tracking
//
// Accepts at most one decoded instruction per cycle when the ROB and the
// target unit (RS for ALU ops, LSB for loads/stores) both have room. Each
// accepted instruction gets a nonzero ROB tag (tags run 1..2^ROB_BIT-1, tag 0
// means "no dependency") and is presented to the register file one cycle
// later through a pipeline register. A branch mispredict clears all credits
// and restarts tag allocation at 1.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   en                  global enable; low holds all state (br_flag/rst still act)
//   br_flag             mispredict flush
//   dec_valid_i         decoder offers an instruction
//   dec_ready_o         controller accepts this cycle (combinational)
//   dec_tp_i            01 load, 10 store, anything else goes to the RS
//   dec_ic_i            compressed flag
//   dec_rd/rs1/rs2_i    register indices
//   dec_op_i            opcode
//   dec_imm_i, dec_pc_i immediate, pc
//   rob_commit_i        ROB retired one entry
//   rs_release_i        one RS entry freed
//   lsb_release_i       one LSB entry freed
//   is_en_o             one-cycle issue strobe to the register file
//   is_*_o              registered copies of the accepted decoder fields
//   rob_qd_o            ROB tag given to the issued instruction
//   rob_alloc_o         ROB allocate strobe (same as is_en_o)

module issue_ctrl #(
  parameter int ROB_BIT  = 5,
  parameter int REG_BIT  = 5,
  parameter int OP_W     = 6,
  parameter int DAT_W    = 32,
  parameter int RS_SIZE  = 8,
  parameter int LSB_SIZE = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               br_flag,
  input  logic               dec_valid_i,
  output logic               dec_ready_o,
  input  logic [1:0]         dec_tp_i,
  input  logic               dec_ic_i,
  input  logic [REG_BIT-1:0] dec_rd_i,
  input  logic [REG_BIT-1:0] dec_rs1_i,
  input  logic [REG_BIT-1:0] dec_rs2_i,
  input  logic [OP_W-1:0]    dec_op_i,
  input  logic [DAT_W-1:0]   dec_imm_i,
  input  logic [DAT_W-1:0]   dec_pc_i,
  input  logic               rob_commit_i,
  input  logic               rs_release_i,
  input  logic               lsb_release_i,
  output logic               is_en_o,
  output logic               is_ic_o,
  output logic [1:0]         is_tp_o,
  output logic [REG_BIT-1:0] is_rd_o,
  output logic [REG_BIT-1:0] is_rs1_o,
  output logic [REG_BIT-1:0] is_rs2_o,
  output logic [OP_W-1:0]    is_op_o,
  output logic [DAT_W-1:0]   is_imm_o,
  output logic [DAT_W-1:0]   is_pc_o,
  output logic [ROB_BIT-1:0] rob_qd_o,
  output logic               rob_alloc_o
);

  localparam int RS_W  = $clog2(RS_SIZE + 1);
  localparam int LSB_W = $clog2(LSB_SIZE + 1);

  // All-ones tag is the largest usable tag and also the ROB capacity.
  localparam logic [ROB_BIT-1:0] ROB_CAP = '1;
  localparam logic [ROB_BIT-1:0] TAG_ONE = ROB_BIT'(1);
  localparam logic [RS_W-1:0]    RS_MAX  = RS_W'(RS_SIZE);
  localparam logic [LSB_W-1:0]   LSB_MAX = LSB_W'(LSB_SIZE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ROB_BIT-1:0] rob_cnt_q, rob_cnt_d;
  logic [RS_W-1:0]    rs_cnt_q, rs_cnt_d;
  logic [LSB_W-1:0]   lsb_cnt_q, lsb_cnt_d;
  logic [ROB_BIT-1:0] tail_q, tail_d;

  logic               is_en_q, is_en_d;
  logic               is_ic_q, is_ic_d;
  logic [1:0]         is_tp_q, is_tp_d;
  logic [REG_BIT-1:0] is_rd_q, is_rd_d;
  logic [REG_BIT-1:0] is_rs1_q, is_rs1_d;
  logic [REG_BIT-1:0] is_rs2_q, is_rs2_d;
  logic [OP_W-1:0]    is_op_q, is_op_d;
  logic [DAT_W-1:0]   is_imm_q, is_imm_d;
  logic [DAT_W-1:0]   is_pc_q, is_pc_d;
  logic [ROB_BIT-1:0] rob_qd_q, rob_qd_d;

  logic is_mem;
  logic unit_free;
  logic accept;
  logic acc_rs;
  logic acc_lsb;
  logic rob_dec;
  logic rs_dec;
  logic lsb_dec;

  // ---------------------------------------------------------------------------
  // Readiness. Only registered counters are consulted, so a commit or release
  // in the same cycle never opens a slot until the next cycle.
  // ---------------------------------------------------------------------------
  assign is_mem    = (dec_tp_i == 2'b01) || (dec_tp_i == 2'b10);
  assign unit_free = is_mem ? (lsb_cnt_q < LSB_MAX) : (rs_cnt_q < RS_MAX);

  assign dec_ready_o = (state_q == ST_RUN) & en & ~br_flag & ~rst
                     & (rob_cnt_q < ROB_CAP) & unit_free;

  assign accept  = dec_valid_i & dec_ready_o;
  assign acc_rs  = accept & ~is_mem;
  assign acc_lsb = accept & is_mem;

  // Decrements are dropped when the counter is already empty.
  assign rob_dec = rob_commit_i  & (rob_cnt_q != '0);
  assign rs_dec  = rs_release_i  & (rs_cnt_q  != '0);
  assign lsb_dec = lsb_release_i & (lsb_cnt_q != '0);

  // ---------------------------------------------------------------------------
  // State machine. A flush overrides everything but reset and may arrive in
  // any state; with en low and no flush the state holds.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (br_flag) begin
      state_d = ST_FLUSH;
    end else if (en) begin
      case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_RUN;
        ST_FLUSH: state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Credit counters and tag pointer.
  // ---------------------------------------------------------------------------
  always_comb begin
    rob_cnt_d = rob_cnt_q;
    rs_cnt_d  = rs_cnt_q;
    lsb_cnt_d = lsb_cnt_q;
    tail_d    = tail_q;

    if (br_flag) begin
      rob_cnt_d = '0;
      rs_cnt_d  = '0;
      lsb_cnt_d = '0;
      tail_d    = TAG_ONE;
    end else if (en) begin
      case ({accept, rob_dec})
        2'b10:   rob_cnt_d = rob_cnt_q + TAG_ONE;
        2'b01:   rob_cnt_d = rob_cnt_q - TAG_ONE;
        default: rob_cnt_d = rob_cnt_q;
      endcase

      case ({acc_rs, rs_dec})
        2'b10:   rs_cnt_d = rs_cnt_q + RS_W'(1);
        2'b01:   rs_cnt_d = rs_cnt_q - RS_W'(1);
        default: rs_cnt_d = rs_cnt_q;
      endcase

      case ({acc_lsb, lsb_dec})
        2'b10:   lsb_cnt_d = lsb_cnt_q + LSB_W'(1);
        2'b01:   lsb_cnt_d = lsb_cnt_q - LSB_W'(1);
        default: lsb_cnt_d = lsb_cnt_q;
      endcase

      // Tag 0 is reserved, so the pointer wraps from the top tag back to 1.
      if (accept) begin
        tail_d = (tail_q == ROB_CAP) ? TAG_ONE : tail_q + TAG_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Issue pipeline register. accept is already low during a flush or while
  // disabled, so the strobe needs no extra gating.
  // ---------------------------------------------------------------------------
  always_comb begin
    is_en_d  = accept;
    is_ic_d  = is_ic_q;
    is_tp_d  = is_tp_q;
    is_rd_d  = is_rd_q;
    is_rs1_d = is_rs1_q;
    is_rs2_d = is_rs2_q;
    is_op_d  = is_op_q;
    is_imm_d = is_imm_q;
    is_pc_d  = is_pc_q;
    rob_qd_d = rob_qd_q;

    if (br_flag) begin
      is_ic_d  = 1'b0;
      is_tp_d  = '0;
      is_rd_d  = '0;
      is_rs1_d = '0;
      is_rs2_d = '0;
      is_op_d  = '0;
      is_imm_d = '0;
      is_pc_d  = '0;
      rob_qd_d = '0;
    end else if (accept) begin
      is_ic_d  = dec_ic_i;
      is_tp_d  = dec_tp_i;
      is_rd_d  = dec_rd_i;
      is_rs1_d = dec_rs1_i;
      is_rs2_d = dec_rs2_i;
      is_op_d  = dec_op_i;
      is_imm_d = dec_imm_i;
      is_pc_d  = dec_pc_i;
      rob_qd_d = tail_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rob_cnt_q <= '0;
      rs_cnt_q  <= '0;
      lsb_cnt_q <= '0;
      tail_q    <= TAG_ONE;
      is_en_q   <= 1'b0;
      is_ic_q   <= 1'b0;
      is_tp_q   <= '0;
      is_rd_q   <= '0;
      is_rs1_q  <= '0;
      is_rs2_q  <= '0;
      is_op_q   <= '0;
      is_imm_q  <= '0;
      is_pc_q   <= '0;
      rob_qd_q  <= '0;
    end else begin
      state_q   <= state_d;
      rob_cnt_q <= rob_cnt_d;
      rs_cnt_q  <= rs_cnt_d;
      lsb_cnt_q <= lsb_cnt_d;
      tail_q    <= tail_d;
      is_en_q   <= is_en_d;
      is_ic_q   <= is_ic_d;
      is_tp_q   <= is_tp_d;
      is_rd_q   <= is_rd_d;
      is_rs1_q  <= is_rs1_d;
      is_rs2_q  <= is_rs2_d;
      is_op_q   <= is_op_d;
      is_imm_q  <= is_imm_d;
      is_pc_q   <= is_pc_d;
      rob_qd_q  <= rob_qd_d;
    end
  end

  assign is_en_o     = is_en_q;
  assign is_ic_o     = is_ic_q;
  assign is_tp_o     = is_tp_q;
  assign is_rd_o     = is_rd_q;
  assign is_rs1_o    = is_rs1_q;
  assign is_rs2_o    = is_rs2_q;
  assign is_op_o     = is_op_q;
  assign is_imm_o    = is_imm_q;
  assign is_pc_o     = is_pc_q;
  assign rob_qd_o    = rob_qd_q;
  assign rob_alloc_o = is_en_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// tb/tb_issue_ctrl.sv - self-checking bench for issue_ctrl against a queue-based reference model

module tb_issue_ctrl;

  localparam int ROB_BIT  = 3;
  localparam int REG_BIT  = 5;
  localparam int OP_W     = 6;
  localparam int DAT_W    = 32;
  localparam int RS_SIZE  = 2;
  localparam int LSB_SIZE = 2;
  localparam int ROB_CAP  = 7;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               en = 1'b0;
  logic               br_flag = 1'b0;
  logic               dec_valid_i = 1'b0;
  logic               dec_ready_o;
  logic [1:0]         dec_tp_i = '0;
  logic               dec_ic_i = 1'b0;
  logic [REG_BIT-1:0] dec_rd_i = '0;
  logic [REG_BIT-1:0] dec_rs1_i = '0;
  logic [REG_BIT-1:0] dec_rs2_i = '0;
  logic [OP_W-1:0]    dec_op_i = '0;
  logic [DAT_W-1:0]   dec_imm_i = '0;
  logic [DAT_W-1:0]   dec_pc_i = '0;
  logic               rob_commit_i = 1'b0;
  logic               rs_release_i = 1'b0;
  logic               lsb_release_i = 1'b0;
  logic               is_en_o;
  logic               is_ic_o;
  logic [1:0]         is_tp_o;
  logic [REG_BIT-1:0] is_rd_o;
  logic [REG_BIT-1:0] is_rs1_o;
  logic [REG_BIT-1:0] is_rs2_o;
  logic [OP_W-1:0]    is_op_o;
  logic [DAT_W-1:0]   is_imm_o;
  logic [DAT_W-1:0]   is_pc_o;
  logic [ROB_BIT-1:0] rob_qd_o;
  logic               rob_alloc_o;

  always #5 clk = ~clk;

  issue_ctrl #(
    .ROB_BIT(ROB_BIT), .REG_BIT(REG_BIT), .OP_W(OP_W), .DAT_W(DAT_W),
    .RS_SIZE(RS_SIZE), .LSB_SIZE(LSB_SIZE)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .br_flag(br_flag),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o), .dec_tp_i(dec_tp_i),
    .dec_ic_i(dec_ic_i), .dec_rd_i(dec_rd_i), .dec_rs1_i(dec_rs1_i), .dec_rs2_i(dec_rs2_i),
    .dec_op_i(dec_op_i), .dec_imm_i(dec_imm_i), .dec_pc_i(dec_pc_i),
    .rob_commit_i(rob_commit_i), .rs_release_i(rs_release_i), .lsb_release_i(lsb_release_i),
    .is_en_o(is_en_o), .is_ic_o(is_ic_o), .is_tp_o(is_tp_o), .is_rd_o(is_rd_o),
    .is_rs1_o(is_rs1_o), .is_rs2_o(is_rs2_o), .is_op_o(is_op_o), .is_imm_o(is_imm_o),
    .is_pc_o(is_pc_o), .rob_qd_o(rob_qd_o), .rob_alloc_o(rob_alloc_o)
  );

  int checks = 0;
  int passes = 0;

  // Reference model: in-flight ROB tags as a queue, unit occupancy as plain
  // integers, and the number of cycles left before the controller is running.
  int m_rob[$];
  int m_rs;
  int m_lsb;
  int m_wait;
  int m_last;

  logic               e_en;
  logic               e_ic;
  logic [1:0]         e_tp;
  logic [REG_BIT-1:0] e_rd, e_rs1, e_rs2;
  logic [OP_W-1:0]    e_op;
  logic [DAT_W-1:0]   e_imm, e_pc;
  logic [ROB_BIT-1:0] e_tag;

  function automatic bit m_is_mem();
    return (dec_tp_i == 2'b01) || (dec_tp_i == 2'b10);
  endfunction

  function automatic bit m_ready();
    bit room;
    room = m_is_mem() ? (m_lsb < LSB_SIZE) : (m_rs < RS_SIZE);
    return !rst && en && !br_flag && (m_wait == 0) && (m_rob.size() < ROB_CAP) && room;
  endfunction

  function automatic void m_clear();
    m_rob.delete();
    m_rs = 0; m_lsb = 0; m_wait = 1; m_last = 0;
    e_en = 0; e_ic = 0; e_tp = '0; e_rd = '0; e_rs1 = '0; e_rs2 = '0;
    e_op = '0; e_imm = '0; e_pc = '0; e_tag = '0;
  endfunction

  function automatic void model_step();
    bit acc;
    int tag;
    if (rst || br_flag) begin
      m_clear();
    end else if (!en) begin
      e_en = 0;
    end else begin
      acc = dec_valid_i && m_ready();
      if (rob_commit_i && m_rob.size() > 0) void'(m_rob.pop_front());
      if (rs_release_i && m_rs > 0) m_rs--;
      if (lsb_release_i && m_lsb > 0) m_lsb--;
      e_en = acc;
      if (acc) begin
        tag = (m_last % ROB_CAP) + 1;
        m_rob.push_back(tag);
        m_last = tag;
        if (m_is_mem()) m_lsb++; else m_rs++;
        e_tag = ROB_BIT'(tag);
        e_ic = dec_ic_i; e_tp = dec_tp_i; e_rd = dec_rd_i; e_rs1 = dec_rs1_i;
        e_rs2 = dec_rs2_i; e_op = dec_op_i; e_imm = dec_imm_i; e_pc = dec_pc_i;
      end
      if (m_wait > 0) m_wait--;
    end
  endfunction

  task automatic drive(input logic v, input logic [1:0] tp, input logic cm,
                       input logic rsr, input logic lsr, input logic b, input logic e);
    @(negedge clk);
    dec_valid_i = v; dec_tp_i = tp; rob_commit_i = cm;
    rs_release_i = rsr; lsb_release_i = lsr; br_flag = b; en = e;
    dec_ic_i  = 1'($urandom);
    dec_rd_i  = REG_BIT'($urandom);
    dec_rs1_i = REG_BIT'($urandom);
    dec_rs2_i = REG_BIT'($urandom);
    dec_op_i  = OP_W'($urandom);
    dec_imm_i = DAT_W'($urandom);
    dec_pc_i  = DAT_W'($urandom);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [REG_BIT-1:0] rd_in;
    rst = 1'b1;
    drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (dec_ready_o !== 1'b0) $display("FAIL reset_ready got=%b want=0", dec_ready_o); else passes++;
    tick();
    checks++;
    if ({is_en_o, rob_alloc_o, rob_qd_o, is_rd_o, is_imm_o} !== '0)
      $display("FAIL reset_outputs en=%b alloc=%b qd=%0d rd=%0d imm=%h want all 0",
               is_en_o, rob_alloc_o, rob_qd_o, is_rd_o, is_imm_o);
    else passes++;
    rst = 1'b0;
    drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (dec_ready_o !== 1'b0) $display("FAIL idle_ready got=%b want=0", dec_ready_o); else passes++;
    tick();
    checks++; if (is_en_o !== 1'b0) $display("FAIL idle_no_issue got=%b want=0", is_en_o); else passes++;
    drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    rd_in = dec_rd_i;
    checks++; if (dec_ready_o !== 1'b1) $display("FAIL first_ready got=%b want=1", dec_ready_o); else passes++;
    tick();
    checks++;
    if (is_en_o !== 1'b1 || rob_alloc_o !== 1'b1 || rob_qd_o !== 3'd1 || is_rd_o !== rd_in)
      $display("FAIL first_issue en=%b alloc=%b tag=%0d rd=%0d want 1 1 1 %0d",
               is_en_o, rob_alloc_o, rob_qd_o, is_rd_o, rd_in);
    else passes++;
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checks++;
    if (is_en_o !== 1'b0 || rob_qd_o !== 3'd1 || is_rd_o !== rd_in)
      $display("FAIL issue_pulse_hold en=%b tag=%0d rd=%0d want 0 1 %0d", is_en_o, rob_qd_o, is_rd_o, rd_in);
    else passes++;
  endtask

  task automatic test_rs_full();
    do_reset();
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, (i == 1) ? 2'b11 : 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (dec_ready_o !== m_ready() || dec_ready_o !== (i < 2))
        $display("FAIL rs_full_ready[%0d] got=%b want=%b", i, dec_ready_o, i < 2);
      else passes++;
      tick();
      checks++;
      if (is_en_o !== e_en || (e_en && rob_qd_o !== ROB_BIT'(i + 1)))
        $display("FAIL rs_full_issue[%0d] en=%b tag=%0d want en=%b tag=%0d", i, is_en_o, rob_qd_o, e_en, i + 1);
      else passes++;
    end
    drive(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++; if (dec_ready_o !== 1'b0) $display("FAIL rs_release_same_cycle got=%b want=0", dec_ready_o); else passes++;
    tick();
    drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (dec_ready_o !== 1'b1) $display("FAIL rs_after_release got=%b want=1", dec_ready_o); else passes++;
    tick();
    checks++;
    if (is_en_o !== 1'b1 || rob_qd_o !== 3'd3) $display("FAIL rs_third_tag en=%b tag=%0d want 1 3", is_en_o, rob_qd_o);
    else passes++;
  endtask

  task automatic test_rob_wrap();
    do_reset();
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, 2'($urandom), 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      checks++; if (dec_ready_o !== m_ready()) $display("FAIL wrap_ready[%0d] got=%b want=%b", i, dec_ready_o, m_ready()); else passes++;
      tick();
      checks++;
      if (is_en_o !== e_en || rob_qd_o !== e_tag)
        $display("FAIL wrap_issue[%0d] en=%b tag=%0d want %b %0d", i, is_en_o, rob_qd_o, e_en, e_tag);
      else passes++;
    end
    drive(1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    checks++; if (dec_ready_o !== 1'b0) $display("FAIL rob_full_ready got=%b want=0", dec_ready_o); else passes++;
    tick();
    checks++; if (is_en_o !== 1'b0) $display("FAIL rob_full_commit_issue got=%b want=0", is_en_o); else passes++;
    drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (dec_ready_o !== 1'b1) $display("FAIL rob_after_commit got=%b want=1", dec_ready_o); else passes++;
    tick();
    checks++;
    if (is_en_o !== 1'b1 || rob_qd_o !== 3'd1) $display("FAIL rob_wrap_tag en=%b tag=%0d want 1 1", is_en_o, rob_qd_o);
    else passes++;
  endtask

  task automatic test_commit_accept();
    int n_acc;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'($urandom), 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      tick();
    end
    drive(1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    checks++; if (dec_ready_o !== 1'b1) $display("FAIL commit_accept_ready got=%b want=1", dec_ready_o); else passes++;
    tick();
    checks++;
    if (is_en_o !== 1'b1 || rob_qd_o !== 3'd5) $display("FAIL commit_accept_tag en=%b tag=%0d want 1 5", is_en_o, rob_qd_o);
    else passes++;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 2'($urandom), 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      tick();
      if (is_en_o === 1'b1) n_acc++;
    end
    checks++; if (n_acc != 3) $display("FAIL commit_accept_room got=%0d accepts want=3", n_acc); else passes++;
    checks++; if (rob_qd_o !== e_tag || e_tag !== 3'd1) $display("FAIL commit_accept_last_tag got=%0d want=1", rob_qd_o); else passes++;
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    checks++; if (rob_qd_o !== 3'd5) $display("FAIL flush_setup_tag got=%0d want=5", rob_qd_o); else passes++;
    drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++; if (dec_ready_o !== 1'b0) $display("FAIL flush_ready got=%b want=0", dec_ready_o); else passes++;
    tick();
    checks++;
    if ({is_en_o, rob_qd_o, is_rd_o, is_pc_o, is_tp_o} !== '0)
      $display("FAIL flush_clear en=%b tag=%0d rd=%0d pc=%h tp=%b want all 0", is_en_o, rob_qd_o, is_rd_o, is_pc_o, is_tp_o);
    else passes++;
    drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (dec_ready_o !== 1'b0) $display("FAIL flush_state_ready got=%b want=0", dec_ready_o); else passes++;
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++; if (dec_ready_o !== 1'b1) $display("FAIL post_flush_ready[%0d] got=%b want=1", i, dec_ready_o); else passes++;
      tick();
      checks++;
      if (is_en_o !== 1'b1 || rob_qd_o !== ROB_BIT'(i + 1))
        $display("FAIL post_flush_tag[%0d] en=%b tag=%0d want 1 %0d", i, is_en_o, rob_qd_o, i + 1);
      else passes++;
    end
  endtask

  task automatic test_enable();
    do_reset();
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (dec_ready_o !== 1'b0) $display("FAIL en_low_ready got=%b want=0", dec_ready_o); else passes++;
    tick();
    checks++;
    if (is_en_o !== 1'b0 || rob_qd_o !== 3'd1) $display("FAIL en_low_hold en=%b tag=%0d want 0 1", is_en_o, rob_qd_o);
    else passes++;
    drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checks++;
    if (is_en_o !== 1'b1 || rob_qd_o !== 3'd2) $display("FAIL en_resume_tag en=%b tag=%0d want 1 2", is_en_o, rob_qd_o);
    else passes++;
    drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (dec_ready_o !== 1'b0) $display("FAIL en_low_release_ignored got=%b want=0", dec_ready_o); else passes++;
    tick();
  endtask

  task automatic test_random();
    logic v, cm, rsr, lsr, b, e;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      v   = 1'($urandom_range(0, 3) != 0);
      cm  = 1'($urandom_range(0, 2) == 0);
      rsr = 1'($urandom_range(0, 2) == 0);
      lsr = 1'($urandom_range(0, 2) == 0);
      b   = 1'($urandom_range(0, 39) == 0);
      e   = 1'($urandom_range(0, 7) != 0);
      drive(v, 2'($urandom), cm, rsr, lsr, b, e);
      checks++;
      if (dec_ready_o !== m_ready()) $display("FAIL rand_ready[%0d] got=%b want=%b", i, dec_ready_o, m_ready());
      else passes++;
      tick();
      checks++;
      if ({is_en_o, rob_alloc_o, rob_qd_o, is_ic_o, is_tp_o, is_rd_o, is_rs1_o, is_rs2_o, is_op_o, is_imm_o, is_pc_o} !==
          {e_en, e_en, e_tag, e_ic, e_tp, e_rd, e_rs1, e_rs2, e_op, e_imm, e_pc})
        $display("FAIL rand_issue[%0d] en=%b tag=%0d rd=%0d op=%0d pc=%h want en=%b tag=%0d rd=%0d op=%0d pc=%h",
                 i, is_en_o, rob_qd_o, is_rd_o, is_op_o, is_pc_o, e_en, e_tag, e_rd, e_op, e_pc);
      else passes++;
    end
  endtask

  initial begin
    m_clear();
    test_reset();
    test_rs_full();
    test_rob_wrap();
    test_commit_accept();
    test_flush();
    test_enable();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
